// File: rtl/irq_ctrl4.sv
// irq_ctrl4 - four-input interrupt controller.
// Captures requests into a pending register, qualifies them with a mask and
// picks a winner with a 4-to-2 priority encoder (line 3 highest). The winner
// is held on a level irq/ack handshake; its pending bit clears on ack.
//
// Ports:
//   clk      system clock, rising edge
//   rst_n    asynchronous active-low reset
//   req      [3:0] request lines, synchronous to clk
//   mask     [3:0] per-line enable (masked lines still accumulate pending)
//   ack      consumer acknowledge, level
//   irq      interrupt request to consumer
//   id       [1:0] source number, valid while irq = 1, held otherwise
//   pending  [3:0] raw pending register
//
// Parameter EDGE: 1 = pending set on a rising edge of req, 0 = set while high.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | irq low; latch encoder winner and advance when any is set
// S_ASSRT | irq high, id frozen; on ack clear pending[id]
// S_REL   | irq low; wait for ack to drop before re-arbitrating

module irq_ctrl4 #(
  parameter bit EDGE = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic [3:0] mask,
  input  logic       ack,
  output logic       irq,
  output logic [1:0] id,
  output logic [3:0] pending
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ASSRT = 2'd1,
    S_REL   = 2'd2
  } state_t;

  state_t     state, state_nx;
  logic [3:0] req_q;
  logic [3:0] set;
  logic [3:0] clr;
  logic [3:0] eff;
  logic [1:0] sel;
  logic [1:0] id_nx;
  logic       any;

  assign set = EDGE ? (req & ~req_q) : req;
  assign eff = pending & mask;

  always_comb begin
    any = |eff;
    sel = 2'd0;
    if (eff[3])      sel = 2'd3;
    else if (eff[2]) sel = 2'd2;
    else if (eff[1]) sel = 2'd1;
    else             sel = 2'd0;
  end

  always_comb begin
    state_nx = state;
    id_nx    = id;
    clr      = 4'b0000;
    irq      = 1'b0;
    case (state)
      S_IDLE: begin
        if (any) begin
          id_nx    = sel;
          state_nx = S_ASSRT;
        end
      end
      S_ASSRT: begin
        irq = 1'b1;
        if (ack) begin
          clr      = 4'b0001 << id;
          state_nx = S_REL;
        end
      end
      S_REL: begin
        if (!ack) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      id      <= 2'd0;
      req_q   <= 4'b0000;
      pending <= 4'b0000;
    end else begin
      state   <= state_nx;
      id      <= id_nx;
      req_q   <= req;
      // set has priority over a same-cycle clear
      pending <= set | (pending & ~clr);
    end
  end

endmodule
